// File: rtl/accel_pkg.sv
// Shared systolic-datapath constants and the aligned-row type used by the
// feed side, the output deskew array and the AXI write-back master.
package accel_pkg;

  localparam int unsigned N_LANES = 32;
  localparam int unsigned DATA_W  = 16;

  typedef logic [DATA_W-1:0] row_t [N_LANES-1:0];

  // Address width that stays at least one bit for degenerate depths.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < v) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/aligned_row_fifo.sv
// Synchronous FIFO of aligned rows; a push while full is accepted only when a
// pop frees the head slot in the same cycle.
module aligned_row_fifo
  import accel_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type row_type = row_t
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         clr,
  input  logic                         push,
  input  row_type                      push_data,
  output logic                         full,
  input  logic                         pop,
  output row_type                      pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = clog2_min1(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  row_type          mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/output_deskew_array.sv
// Re-aligns column-skewed systolic results into whole rows, queues them and
// hands them to the write-back side with a valid/ready handshake.
module output_deskew_array
  import accel_pkg::*;
#(
  parameter int unsigned N     = N_LANES,
  parameter int unsigned DW    = DATA_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROWS  = 32
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clr,
  input  logic [N-1:0]  in_vld,
  input  logic [DW-1:0] data_in [N-1:0],
  input  logic          out_rdy,
  output logic          out_vld,
  output logic [DW-1:0] data_out [N-1:0],
  output logic          tile_done,
  output logic          overflow,
  output logic          skew_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = $clog2(ROWS + 1);

  typedef logic [DW-1:0] lane_row_t [N-1:0];

  lane_row_t       al_data;
  lane_row_t       head;
  logic [N-1:0]    al_vld;
  logic            row_all;
  logic            row_any;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [RW-1:0]   row_cnt;

  // Lane j sees N-j registers in total, so a row launched with lane j at
  // t0+j lines up at t0+N across all lanes.
  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int unsigned S = N - j;
    logic [DW-1:0] d [S];
    logic          v [S];

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        for (int unsigned k = 0; k < S; k++) v[k] <= 1'b0;
      end else if (clr) begin
        for (int unsigned k = 0; k < S; k++) v[k] <= 1'b0;
      end else begin
        v[0] <= in_vld[j];
        for (int unsigned k = 1; k < S; k++) v[k] <= v[k-1];
      end
    end

    always_ff @(posedge clk) begin
      d[0] <= data_in[j];
      for (int unsigned k = 1; k < S; k++) d[k] <= d[k-1];
    end

    assign al_vld[j]  = v[S-1];
    assign al_data[j] = d[S-1];
  end

  assign row_all = &al_vld;
  assign row_any = |al_vld;
  assign push    = row_all && !clr;
  assign pop     = out_rdy && !fifo_empty && !clr;
  assign out_vld = (fifo_count != '0);

  aligned_row_fifo #(
    .DEPTH    (DEPTH),
    .row_type (lane_row_t)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .clr       (clr),
    .push      (push),
    .push_data (al_data),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    for (int unsigned j = 0; j < N; j++) data_out[j] = out_vld ? head[j] : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) overflow <= 1'b1;
      if (row_any && !row_all)       skew_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_cnt   <= '0;
      tile_done <= 1'b0;
    end else if (clr) begin
      row_cnt   <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      if (pop) begin
        if (row_cnt == RW'(ROWS - 1)) begin
          row_cnt   <= '0;
          tile_done <= 1'b1;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_output_deskew_array.sv
// Directed bench for output_deskew_array: skewed row launches, alignment,
// FIFO boundary cases, tile counting, clr and asynchronous reset.
module tb_output_deskew_array;

  localparam int N     = 32;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int ROWS  = 32;
  localparam int BAD   = 7;

  logic          clk = 1'b0;
  logic          nrst;
  logic          clr;
  logic [N-1:0]  in_vld;
  logic [DW-1:0] data_in [N-1:0];
  logic          out_rdy;
  logic          out_vld;
  logic [DW-1:0] data_out [N-1:0];
  logic          tile_done;
  logic          overflow;
  logic          skew_err;

  int checks = 0;
  int errors = 0;
  int rel    = 0;
  int s_start = 0;
  int s_nrows = 0;
  int s_tag   = 0;
  int s_bad   = -1;

  output_deskew_array #(
    .N(N), .DW(DW), .DEPTH(DEPTH), .ROWS(ROWS)
  ) dut (
    .clk(clk), .nrst(nrst), .clr(clr), .in_vld(in_vld), .data_in(data_in),
    .out_rdy(out_rdy), .out_vld(out_vld), .data_out(data_out),
    .tile_done(tile_done), .overflow(overflow), .skew_err(skew_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rowval(input int tag, input int r, input int j);
    logic [7:0] hi, lo;
    hi = 8'(tag + r);
    lo = 8'(j);
    return {hi, lo};
  endfunction

  // Lane j of row r is presented in cycle s_start + r + j.
  task automatic drive(input int t);
    for (int j = 0; j < N; j++) begin
      int r;
      r = t - s_start - j;
      if (r >= 0 && r < s_nrows && !(r == s_bad && j == BAD)) begin
        in_vld[j]  = 1'b1;
        data_in[j] = rowval(s_tag, r, j);
      end else begin
        in_vld[j]  = 1'b0;
        data_in[j] = 16'hDEAD;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rel++;
    drive(rel);
  endtask

  task automatic start_stream(input int tag, input int nrows, input int bad);
    s_start = rel;
    s_nrows = nrows;
    s_tag   = tag;
    s_bad   = bad;
    drive(rel);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; clr = 1'b0; out_rdy = 1'b0;
    drive(0);
    #23;
    checks++;
    if (out_vld !== 1'b0 || tile_done !== 1'b0 || overflow !== 1'b0 || skew_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got vld=%b done=%b ovf=%b skew=%b exp all 0",
               out_vld, tile_done, overflow, skew_err);
    end
    checks++;
    if (data_out[0] !== 16'h0 || data_out[N-1] !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h exp 0000", data_out[0], data_out[N-1]);
    end
    nrst = 1'b1;
    step();
  endtask

  task automatic test_single_row();
    int e;
    out_rdy = 1'b1;
    start_stream(8'h01, 1, -1);
    for (int k = 0; k < N + 4; k++) begin
      step();
      e = rel - s_start;
      checks++;
      if (out_vld !== (e == N + 1)) begin
        errors++;
        $display("FAIL single_vld e=%0d got %b exp %b", e, out_vld, (e == N + 1));
      end
      if (e == N + 1) begin
        bit bad = 0;
        checks++;
        for (int j = 0; j < N; j++)
          if (data_out[j] !== 16'h0100 + 16'(j) && !bad) begin
            bad = 1;
            $display("FAIL single_data lane %0d got %h exp %h", j, data_out[j], 16'h0100 + 16'(j));
          end
        if (bad) errors++;
      end
    end
  endtask

  task automatic test_stream();
    int e;
    do_clr();
    out_rdy = 1'b1;
    start_stream(8'h10, ROWS, -1);
    for (int k = 0; k < N + ROWS + 5; k++) begin
      bit exp_v;
      step();
      e = rel - s_start;
      exp_v = (e >= N + 1 && e <= N + ROWS);
      checks++;
      if (out_vld !== exp_v) begin
        errors++;
        $display("FAIL stream_vld e=%0d got %b exp %b", e, out_vld, exp_v);
      end
      checks++;
      if (tile_done !== (e == N + ROWS + 1)) begin
        errors++;
        $display("FAIL stream_tile_done e=%0d got %b exp %b", e, tile_done, (e == N + ROWS + 1));
      end
      if (exp_v) begin
        bit bad = 0;
        checks++;
        for (int j = 0; j < N; j++)
          if (data_out[j] !== rowval(8'h10, e - N - 1, j) && !bad) begin
            bad = 1;
            $display("FAIL stream_data e=%0d lane %0d got %h exp %h", e, j, data_out[j],
                     rowval(8'h10, e - N - 1, j));
          end
        if (bad) errors++;
      end
    end
  endtask

  task automatic test_backpressure();
    int e;
    do_clr();
    out_rdy = 1'b0;
    start_stream(8'h40, 5, -1);
    for (int k = 0; k < N + 14; k++) begin
      int r;
      step();
      e = rel - s_start;
      r = (e >= N + 1 && e <= N + 8) ? 0 : (e >= N + 9 && e <= N + 11) ? e - N - 8 : -1;
      checks++;
      if (out_vld !== (r >= 0)) begin
        errors++;
        $display("FAIL bp_vld e=%0d got %b exp %b", e, out_vld, (r >= 0));
      end
      checks++;
      if (overflow !== (e >= N + 5)) begin
        errors++;
        $display("FAIL bp_overflow e=%0d got %b exp %b", e, overflow, (e >= N + 5));
      end
      if (r >= 0) begin
        bit bad = 0;
        checks++;
        for (int j = 0; j < N; j++)
          if (data_out[j] !== rowval(8'h40, r, j) && !bad) begin
            bad = 1;
            $display("FAIL bp_data e=%0d lane %0d got %h exp %h", e, j, data_out[j], rowval(8'h40, r, j));
          end
        if (bad) errors++;
      end
      if (e == N + 8) out_rdy = 1'b1;
    end
  endtask

  task automatic test_full_push_pop();
    int e;
    do_clr();
    out_rdy = 1'b0;
    start_stream(8'h60, 6, -1);
    for (int k = 0; k < N + 12; k++) begin
      int r;
      step();
      e = rel - s_start;
      r = (e >= N + 1 && e <= N + 4) ? 0 : (e >= N + 5 && e <= N + 9) ? e - N - 4 : -1;
      checks++;
      if (out_vld !== (r >= 0) || overflow !== 1'b0) begin
        errors++;
        $display("FAIL full_pp_vld e=%0d got vld=%b ovf=%b exp vld=%b ovf=0", e, out_vld, overflow, (r >= 0));
      end
      if (r >= 0) begin
        bit bad = 0;
        checks++;
        for (int j = 0; j < N; j++)
          if (data_out[j] !== rowval(8'h60, r, j) && !bad) begin
            bad = 1;
            $display("FAIL full_pp_data e=%0d lane %0d got %h exp %h", e, j, data_out[j], rowval(8'h60, r, j));
          end
        if (bad) errors++;
      end
      if (e == N + 4) out_rdy = 1'b1;
    end
  endtask

  task automatic test_skew_err();
    int e;
    do_clr();
    out_rdy = 1'b1;
    start_stream(8'h80, 3, 1);
    for (int k = 0; k < N + 6; k++) begin
      int r;
      step();
      e = rel - s_start;
      r = (e == N + 1) ? 0 : (e == N + 3) ? 2 : -1;
      checks++;
      if (out_vld !== (r >= 0)) begin
        errors++;
        $display("FAIL skew_vld e=%0d got %b exp %b", e, out_vld, (r >= 0));
      end
      checks++;
      if (skew_err !== (e >= N + 2) || overflow !== 1'b0) begin
        errors++;
        $display("FAIL skew_flag e=%0d got skew=%b ovf=%b exp skew=%b ovf=0", e, skew_err, overflow, (e >= N + 2));
      end
      if (r >= 0) begin
        bit bad = 0;
        checks++;
        for (int j = 0; j < N; j++)
          if (data_out[j] !== rowval(8'h80, r, j) && !bad) begin
            bad = 1;
            $display("FAIL skew_data e=%0d lane %0d got %h exp %h", e, j, data_out[j], rowval(8'h80, r, j));
          end
        if (bad) errors++;
      end
    end
  endtask

  // Three rows queued, the rest still in the delay lines when clr lands.
  task automatic test_clr_mid_stream();
    int e;
    out_rdy = 1'b0;
    start_stream(8'hA0, 13, -1);
    for (int k = 0; k < N + 3; k++) step();
    e = rel - s_start;
    checks++;
    if (out_vld !== 1'b1 || skew_err !== 1'b1 || data_out[5] !== rowval(8'hA0, 0, 5)) begin
      errors++;
      $display("FAIL clr_pre e=%0d got vld=%b skew=%b d5=%h exp vld=1 skew=1 d5=%h",
               e, out_vld, skew_err, data_out[5], rowval(8'hA0, 0, 5));
    end
    clr = 1'b1;
    out_rdy = 1'b1;
    s_nrows = 0;
    step();
    clr = 1'b0;
    for (int k = 0; k < N + 5; k++) begin
      checks++;
      if (out_vld !== 1'b0 || skew_err !== 1'b0 || overflow !== 1'b0 || tile_done !== 1'b0 ||
          data_out[0] !== 16'h0) begin
        errors++;
        $display("FAIL clr_post k=%0d got vld=%b skew=%b ovf=%b done=%b d0=%h exp all 0",
                 k, out_vld, skew_err, overflow, tile_done, data_out[0]);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    int e;
    out_rdy = 1'b0;
    start_stream(8'hC0, 13, 1);
    for (int k = 0; k < N + 3; k++) step();
    e = rel - s_start;
    checks++;
    if (out_vld !== 1'b1 || skew_err !== 1'b1 || data_out[0] !== rowval(8'hC0, 0, 0)) begin
      errors++;
      $display("FAIL arst_pre e=%0d got vld=%b skew=%b d0=%h exp vld=1 skew=1 d0=%h",
               e, out_vld, skew_err, data_out[0], rowval(8'hC0, 0, 0));
    end
    s_nrows = 0;
    drive(rel);
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b0 || skew_err !== 1'b0 || overflow !== 1'b0 || data_out[0] !== 16'h0) begin
      errors++;
      $display("FAIL arst_now got vld=%b skew=%b ovf=%b d0=%h exp all 0", out_vld, skew_err, overflow, data_out[0]);
    end
    #1 nrst = 1'b1;
    out_rdy = 1'b1;
    for (int k = 0; k < N + 5; k++) begin
      step();
      checks++;
      if (out_vld !== 1'b0 || skew_err !== 1'b0 || tile_done !== 1'b0) begin
        errors++;
        $display("FAIL arst_post k=%0d got vld=%b skew=%b done=%b exp all 0", k, out_vld, skew_err, tile_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_stream();
    test_backpressure();
    test_full_push_pop();
    test_skew_err();
    test_clr_mid_stream();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_deskew_array.md
Name: output_deskew_array

Overview:
- Receiving end of the systolic datapath.
- The feed side skews operands so that lane i enters i cycles late. The array therefore emits results column-skewed: lane j's result for row r arrives j cycles after lane 0's.
- This block re-aligns the N skewed lanes into one aligned row and queues aligned rows in a small FIFO.
- It presents rows to the AXI write-back side with a valid/ready handshake and counts rows per tile.

Parameters:
- N, 32, number of lanes (array columns).
- DW, 16, data width per lane.
- DEPTH, 4, aligned-row FIFO depth (power of 2, >=2).
- ROWS, 32, rows per tile; sets when tile_done pulses.

Ports:
- clk, input, 1, clock.
- nrst, input, 1, reset, asynchronous, active-low.
- clr, input, 1, synchronous tile-start clear.
- in_vld, input, N, per-lane result valid from the array bottom edge.
- data_in, input, N x DW (unpacked [N-1:0]), per-lane result data.
- out_rdy, input, 1, downstream ready.
- out_vld, output, 1, aligned row available.
- data_out, output, N x DW (unpacked), aligned row; lane j is column j.
- tile_done, output, 1, one-cycle pulse when the ROWS-th row is popped.
- overflow, output, 1, sticky: a row was dropped because the FIFO was full.
- skew_err, output, 1, sticky: partial alignment (some but not all aligned valids high).

Behaviour:
- Reset (nrst low, asynchronous) clears all delay-line valids, FIFO pointers/count, the row counter and both sticky flags.
  - out_vld=0, tile_done=0, overflow=0, skew_err=0, data_out='0.
  - Delay-line data registers need not be reset.
- Deskew path:
  - Every lane has one input register.
  - Lane j then passes through N-1-j further register stages, carrying data and valid together. Lane N-1 has no extra stages.
  - Total lane-j delay to the aligned point is N-j cycles.
  - If lane j presents row r at cycle t0+j, for all j, the aligned row is complete at cycle t0+N.
- Alignment check at the aligned point:
  - All N aligned valids high: push the row into the FIFO.
  - None high: no action.
  - Some but not all high: row dropped, skew_err set (sticky).
- FIFO:
  - Synchronous, DEPTH entries.
  - Push at the t0+N edge; out_vld rises in cycle t0+N+1 if the FIFO was empty. Input-to-output latency is N+1 cycles from lane 0.
  - out_vld = (count != 0).
  - data_out = head entry when out_vld=1, else '0.
  - Pop on the edge where out_vld && out_rdy.
  - Head data and out_vld stay stable while out_rdy=0 (AXI-style hold).
- Boundary conditions:
  - Push when full and no pop that cycle: row dropped, overflow set (sticky), count unchanged.
  - Push when full with a simultaneous pop: both occur, no overflow, count stays DEPTH.
  - Push and pop when count=1: count stays 1; the new row becomes head on the next cycle.
  - Pointers wrap modulo DEPTH.
- Row counter (width clog2(ROWS+1)):
  - Increments on each pop.
  - On the pop that makes it equal ROWS: tile_done=1 for exactly the following cycle (registered), and the counter returns to 0.
- clr (synchronous, highest priority after reset):
  - Zeroes delay-line valids, FIFO count/pointers, row counter, tile_done, overflow and skew_err.
  - in_vld in the clr cycle is ignored.
  - No pop occurs in the clr cycle even if out_rdy=1.
  - out_vld=0 in the next cycle.
- Reset mid-operation: all in-flight rows are lost; no partial row may appear after reset deassertion.
- Throughput: one aligned row per cycle sustained while out_rdy=1. No bubbles are inserted by the block.

Decomposition:
- Shared package (accel_pkg):
  - Constants for lane count and data width.
  - Typedef row_t = logic [DW-1:0] row_t [N] for aligned rows.
  - These are shared with the feed-side array and the AXI write-back master.
- Sub-module aligned_row_fifo: parameterised by DEPTH, row_t payload, push/full/pop/empty/count.
- Deskew lanes are a generate loop in the top; no sub-module is needed.

Test Plan:
1. Single row, default params:
   - Stimulus: lane j driven with value 16'h0100+j, valid at cycle t0+j, out_rdy=1.
   - Required: out_vld high only in cycle t0+33, data_out[j]=16'h0100+j.
2. Streaming ROWS=32 rows back-to-back, out_rdy=1:
   - Required: 32 consecutive out_vld cycles, rows in order.
   - Required: tile_done single pulse the cycle after the 32nd pop; counter back to 0.
3. Backpressure:
   - Stimulus: out_rdy=0; stream 5 rows with DEPTH=4.
   - Required: first 4 rows held unchanged, 5th dropped, overflow=1.
   - Then out_rdy=1: exactly 4 rows popped, overflow stays 1.
4. Full with simultaneous push/pop:
   - Stimulus: FIFO at 4 entries, out_rdy=1, new row arriving.
   - Required: no overflow, count stays 4, order preserved.
5. Skew error:
   - Stimulus: drop lane 7 valid for one row.
   - Required: that row never appears, skew_err=1, neighbouring rows intact.
6. clr and reset mid-stream:
   - Stimulus: clr asserted with 3 rows queued and 10 in the delay lines.
   - Required: out_vld=0 next cycle, flags cleared, no stale row emitted.
   - Repeat the same stimulus with an asynchronous nrst pulse between clock edges: outputs reset immediately.
